// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority over the
// multi-cycle unit, which is forced through after STARVE_LIMIT consecutive denials.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ready_o,
  input  logic        mc_valid_i,
  input  logic [4:0]  mc_rd_i,
  input  logic [31:0] mc_data_i,
  output logic        mc_ready_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        force_o
);

  typedef enum logic {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} state_e;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  reg_waddr_q, reg_waddr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        grant_wb, grant_mc, mc_denied;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // State and write-port registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_NORMAL;
      cnt_q       <= 4'd0;
      reg_write_q <= 1'b0;
      reg_waddr_q <= 5'd0;
      reg_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_write_q <= reg_write_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // Grants look only at state and valids; in FORCE the pipeline is held off even
  // when the multi-cycle request has been withdrawn.
  always_comb begin
    grant_wb = 1'b0;
    grant_mc = 1'b0;
    if (!rst_i) begin
      if (state_q == ST_FORCE) grant_mc = mc_valid_i;
      else if (wb_valid_i)     grant_wb = 1'b1;
      else                     grant_mc = mc_valid_i;
    end
    mc_denied = mc_valid_i && !grant_mc;
  end

  assign wb_ready_o  = grant_wb;
  assign mc_ready_o  = grant_mc;
  assign force_o     = (state_q == ST_FORCE);
  assign reg_write_o = reg_write_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (mc_denied && (cnt_q == LIMIT_M1)) state_d = ST_FORCE;
      ST_FORCE:  if (grant_mc || !mc_valid_i)          state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    cnt_d       = mc_denied ? sat_inc(cnt_q) : 4'd0;
    reg_write_d = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    // Writes to x0 complete the handshake but leave the port untouched.
    if (grant_wb && (wb_rd_i != 5'd0)) begin
      reg_write_d = 1'b1;
      reg_waddr_d = wb_rd_i;
      reg_wdata_d = wb_data_i;
    end else if (grant_mc && (mc_rd_i != 5'd0)) begin
      reg_write_d = 1'b1;
      reg_waddr_d = mc_rd_i;
      reg_wdata_d = mc_data_i;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand sequences for reset and
// withdrawal in FORCE, then randomized traffic against a denial-streak model.
module tb_rf_write_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wb_valid_i, mc_valid_i;
  logic [4:0]  wb_rd_i, mc_rd_i;
  logic [31:0] wb_data_i, mc_data_i;
  logic        wb_ready_o, mc_ready_o, reg_write_o, force_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_ready_o(wb_ready_o),
    .mc_valid_i(mc_valid_i), .mc_rd_i(mc_rd_i), .mc_data_i(mc_data_i), .mc_ready_o(mc_ready_o),
    .reg_write_o(reg_write_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .force_o(force_o)
  );

  typedef struct {
    logic        rst, wv, mv;
    logic [4:0]  wrd, mrd;
    logic [31:0] wd, md;
    logic        e_wr, e_mr, e_f, e_w;
    logic [4:0]  e_a;
    logic [31:0] e_d;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic wv, logic [4:0] wrd, logic [31:0] wd,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic e_wr, logic e_mr, logic e_f, logic e_w,
                              logic [4:0] e_a, logic [31:0] e_d);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wrd = wrd; v.wd = wd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_wr = e_wr; v.e_mr = e_mr; v.e_f = e_f; v.e_w = e_w; v.e_a = e_a; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_wr, input logic e_mr, input logic e_f,
                         input logic e_w, input logic [4:0] e_a, input logic [31:0] e_d);
    chk({tag, ".wb_ready"},  32'(wb_ready_o),  32'(e_wr));
    chk({tag, ".mc_ready"},  32'(mc_ready_o),  32'(e_mr));
    chk({tag, ".force"},     32'(force_o),     32'(e_f));
    chk({tag, ".reg_write"}, 32'(reg_write_o), 32'(e_w));
    chk({tag, ".waddr"},     32'(reg_waddr_o), 32'(e_a));
    chk({tag, ".wdata"},     reg_wdata_o,      e_d);
  endtask

  task automatic drv(input logic rst, input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    rst_i = rst; wb_valid_i = wv; wb_rd_i = wrd; wb_data_i = wd;
    mc_valid_i = mv; mc_rd_i = mrd; mc_data_i = md;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: consecutive-denial streak and last committed write.
  int          m_den;
  logic        m_w;
  logic [4:0]  m_a;
  logic [31:0] m_d;

  initial begin
    drv(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    next_cycle();
    drv(1'b1, 1'b1, 5'd6, 32'h6, 1'b1, 5'd7, 32'h7);
    #4 chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    next_cycle();

    // rst wv wrd wd mv mrd md | wb_rdy mc_rdy force write addr data
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 0,0,0));
    vt.push_back(mk(0,1,5,32'hDEADBEEF, 0,0,0,            1,0,0, 0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 1,5,32'hDEADBEEF));
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 0,5,32'hDEADBEEF));
    vt.push_back(mk(0,1,3,32'h11,       1,4,32'h22,       1,0,0, 0,5,32'hDEADBEEF));
    vt.push_back(mk(0,0,0,0,            1,4,32'h22,       0,1,0, 1,3,32'h11));
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 1,4,32'h22));
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 0,4,32'h22));
    vt.push_back(mk(0,0,0,0,            1,0,32'hFFFFFFFF, 0,1,0, 0,4,32'h22));
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 0,4,32'h22));
    vt.push_back(mk(0,1,7,32'h70,       1,9,32'h99,       1,0,0, 0,4,32'h22));
    vt.push_back(mk(0,1,7,32'h70,       1,9,32'h99,       1,0,0, 1,7,32'h70));
    vt.push_back(mk(0,1,7,32'h70,       1,9,32'h99,       1,0,0, 1,7,32'h70));
    vt.push_back(mk(0,1,7,32'h70,       1,9,32'h99,       1,0,0, 1,7,32'h70));
    vt.push_back(mk(0,1,7,32'h70,       1,9,32'h99,       0,1,1, 1,7,32'h70));
    vt.push_back(mk(0,1,7,32'h70,       1,9,32'h99,       1,0,0, 1,9,32'h99));
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 1,7,32'h70));
    vt.push_back(mk(0,1,8,32'h80,       1,10,32'hA,       1,0,0, 0,7,32'h70));
    vt.push_back(mk(0,1,8,32'h80,       1,10,32'hA,       1,0,0, 1,8,32'h80));
    vt.push_back(mk(0,1,8,32'h80,       0,10,32'hA,       1,0,0, 1,8,32'h80));
    vt.push_back(mk(0,1,8,32'h80,       1,10,32'hA,       1,0,0, 1,8,32'h80));
    vt.push_back(mk(0,1,8,32'h80,       1,10,32'hA,       1,0,0, 1,8,32'h80));
    vt.push_back(mk(0,1,8,32'h80,       1,10,32'hA,       1,0,0, 1,8,32'h80));
    vt.push_back(mk(0,1,8,32'h80,       1,10,32'hA,       1,0,0, 1,8,32'h80));
    vt.push_back(mk(0,1,8,32'h80,       1,10,32'hA,       0,1,1, 1,8,32'h80));
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 1,10,32'hA));
    vt.push_back(mk(0,0,0,0,            0,0,0,            0,0,0, 0,10,32'hA));

    foreach (vt[i]) begin
      drv(vt[i].rst, vt[i].wv, vt[i].wrd, vt[i].wd, vt[i].mv, vt[i].mrd, vt[i].md);
      #4 chk_all($sformatf("vec%0d", i), vt[i].e_wr, vt[i].e_mr, vt[i].e_f,
                 vt[i].e_w, vt[i].e_a, vt[i].e_d);
      next_cycle();
    end

    // Reset while in FORCE, then a fresh starvation window ending in withdrawal.
    for (int i = 0; i < LIMIT; i++) begin
      drv(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      #4 chk($sformatf("rf_pre%0d.force", i), 32'(force_o), 32'd0);
      next_cycle();
    end
    drv(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    #4 chk("rf_in_force.force", 32'(force_o), 32'd1);
    chk("rf_in_force.mc_ready", 32'(mc_ready_o), 32'd0);
    chk("rf_in_force.wb_ready", 32'(wb_ready_o), 32'd0);
    next_cycle();
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #4 chk_all("rf_after", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    for (int i = 0; i < LIMIT; i++) begin
      drv(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      #4 chk($sformatf("rf_fresh%0d.force", i), 32'(force_o), 32'd0);
      chk($sformatf("rf_fresh%0d.mc_ready", i), 32'(mc_ready_o), 32'd0);
      next_cycle();
    end
    drv(1'b0, 1'b1, 5'd1, 32'h1, 1'b0, 5'd2, 32'h2);
    #4 chk("wd_force.force", 32'(force_o), 32'd1);
    chk("wd_force.wb_ready", 32'(wb_ready_o), 32'd0);
    chk("wd_force.mc_ready", 32'(mc_ready_o), 32'd0);
    next_cycle();
    #4 chk("wd_exit.force", 32'(force_o), 32'd0);
    chk("wd_exit.wb_ready", 32'(wb_ready_o), 32'd1);
    next_cycle();

    // Randomized traffic against the model
    drv(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    m_den = 0; m_w = 1'b0; m_a = 5'd0; m_d = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      logic r, wv, mv, forced, e_wb, e_mc;
      logic [4:0] wrd, mrd;
      logic [31:0] wd, md;
      r   = ($urandom_range(0, 59) == 0);
      wv  = ($urandom_range(0, 3) != 0);
      mv  = ($urandom_range(0, 2) != 0);
      wrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wd  = $urandom;
      md  = $urandom;
      drv(r, wv, wrd, wd, mv, mrd, md);
      forced = (m_den >= LIMIT);
      e_wb = !r && !forced && wv;
      e_mc = !r && mv && (forced || !wv);
      #4 chk_all($sformatf("rnd%0d", c), e_wb, e_mc, forced, m_w, m_a, m_d);
      @(posedge clk);
      if (r) begin
        m_den = 0; m_w = 1'b0; m_a = 5'd0; m_d = 32'd0;
      end else begin
        m_w = 1'b0;
        if (e_wb && wrd != 0)      begin m_w = 1'b1; m_a = wrd; m_d = wd; end
        else if (e_mc && mrd != 0) begin m_w = 1'b1; m_a = mrd; m_d = md; end
        m_den = (mv && !e_mc) ? m_den + 1 : 0;
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
